// File: rtl/conv_result_collector.sv
// Collects pipelined convolver results, drops edge windows, buffers them in a FWFT FIFO with raster addresses.
// Result visible PIPE_LAT+1 cycles after its en; stall backpressures the control path when FIFO plus in-flight fill DEPTH.

// Generic first-word-fall-through FIFO; push and pop in the same cycle are both
// honoured even when full.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BW = $clog2(DEPTH+1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_BW-1:0] wr_ptr;
  logic [PTR_BW-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  function automatic logic [PTR_BW-1:0] ptr_inc(input logic [PTR_BW-1:0] p);
    return (p == PTR_BW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_BW'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module conv_result_collector #(
  parameter int KERNEL_SIZE = 5,
  parameter int WIDTH       = 28,
  parameter int HEIGHT      = 28,
  parameter int DATA_BW     = 16,
  parameter int PIPE_LAT    = 2,
  parameter int DEPTH       = 4,
  parameter int ADDR_BW     = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [DATA_BW-1:0] conv_data,
  output logic               stall,
  output logic               out_valid,
  output logic [DATA_BW-1:0] out_data,
  output logic [ADDR_BW-1:0] out_addr,
  input  logic               out_ready,
  output logic               frame_done,
  output logic               err
);
  localparam int COL_BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_BW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int NOUT   = (WIDTH-KERNEL_SIZE+1) * (HEIGHT-KERNEL_SIZE+1);
  localparam int CNT_BW = $clog2(DEPTH+1);
  localparam int OCC_BW = $clog2(DEPTH+PIPE_LAT+1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_BW-1:0] addr;
    logic [DATA_BW-1:0] dat;
  } res_t;

  state_t              state;
  state_t              state_nxt;
  logic [COL_BW-1:0]   col;
  logic [ROW_BW-1:0]   row;
  logic [ADDR_BW-1:0]  addr_cnt;
  logic [PIPE_LAT-1:0] dl;
  logic                keep;
  logic                last_pix;
  logic                tap;
  logic                pop;
  logic                drain_empty;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CNT_BW-1:0]   fifo_cnt;
  logic [OCC_BW-1:0]   occ;
  res_t                push_dat;
  res_t                head_dat;

  assign keep        = (row >= ROW_BW'(KERNEL_SIZE-1)) && (col >= COL_BW'(KERNEL_SIZE-1));
  assign last_pix    = (row == ROW_BW'(HEIGHT-1)) && (col == COL_BW'(WIDTH-1));
  assign tap         = dl[PIPE_LAT-1];
  assign pop         = out_valid && out_ready;
  assign drain_empty = (dl == '0) && fifo_empty;
  assign push_dat    = '{addr: addr_cnt, dat: conv_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == COL_BW'(WIDTH-1)) begin
        col <= '0;
        row <= (row == ROW_BW'(HEIGHT-1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl <= '0;
    end else begin
      dl[0] <= en && keep;
      for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  // Address advances per kept window even when its push is dropped, so it
  // returns to 0 exactly after the last window of the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (tap) addr_cnt <= (addr_cnt == ADDR_BW'(NOUT-1)) ? '0 : addr_cnt + 1'b1;
      if ((en && stall) || (tap && fifo_full && !pop)) err <= 1'b1;
    end
  end

  fifo #(
    .WIDTH($bits(res_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (tap),
    .push_dat(push_dat),
    .pop     (pop),
    .head_dat(head_dat),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_cnt)
  );

  always_comb begin
    occ = OCC_BW'(fifo_cnt);
    for (int i = 0; i < PIPE_LAT; i++) occ = occ + OCC_BW'(dl[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (en && last_pix) state_nxt = DRAIN;
      DRAIN:   if (drain_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = !fifo_empty;
    out_data   = out_valid ? head_dat.dat : '0;
    out_addr   = out_valid ? head_dat.addr : '0;
    stall      = (occ >= OCC_BW'(DEPTH)) || (state == DRAIN);
    frame_done = (state == DRAIN) && drain_empty;
  end
endmodule

// File: tb/tb_conv_result_collector.sv
// Randomized bench for conv_result_collector: a queue-based model of kept windows
// is compared every cycle, plus literal checks on latency, ordering, drops and reset.
module tb_conv_result_collector;
  localparam int K     = 5;
  localparam int W     = 28;
  localparam int H     = 28;
  localparam int DBW   = 16;
  localparam int PL    = 2;
  localparam int DEPTH = 4;
  localparam int ABW   = 10;
  localparam int NOUT  = (W-K+1)*(H-K+1);
  localparam int NPIX  = W*H;
  localparam int FIRST = (K-1)*W + (K-1);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           en = 1'b0;
  logic           out_ready = 1'b0;
  logic [DBW-1:0] conv_data = '0;
  logic           stall;
  logic           out_valid;
  logic [DBW-1:0] out_data;
  logic [ABW-1:0] out_addr;
  logic           frame_done;
  logic           err;

  always #5 clk = ~clk;

  conv_result_collector #(
    .KERNEL_SIZE(K), .WIDTH(W), .HEIGHT(H), .DATA_BW(DBW),
    .PIPE_LAT(PL), .DEPTH(DEPTH), .ADDR_BW(ABW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .conv_data(conv_data),
    .stall(stall), .out_valid(out_valid), .out_data(out_data),
    .out_addr(out_addr), .out_ready(out_ready),
    .frame_done(frame_done), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { int addr; int dat; } res_t;

  res_t mq[$];       // results the FIFO should hold, head first
  int   fl[$];       // edge numbers at which in-flight kept pixels reach the FIFO
  int   cyc = 0;
  int   m_pix = 0;
  int   m_addr = 0;
  bit   m_draining = 1'b0;
  bit   m_err = 1'b0;
  bit   s_vld = 1'b0;
  int   s_addr = 0;
  int   s_dat = 0;
  res_t pops[$];     // results the DUT actually handed over
  int   fd_seen = 0;
  int   first_vld_cyc = -1;

  function automatic bit m_stall();
    return ((mq.size() + fl.size()) >= DEPTH) || m_draining;
  endfunction

  function automatic bit m_fd();
    return m_draining && (mq.size() == 0) && (fl.size() == 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    bit st;
    bit fd;
    bit do_pop;
    if (!reset) begin
      mq.delete();
      fl.delete();
      m_pix      = 0;
      m_addr     = 0;
      m_draining = 1'b0;
      m_err      = 1'b0;
    end else begin
      st     = m_stall();
      fd     = m_fd();
      do_pop = (mq.size() > 0) && out_ready;
      if (s_vld && out_ready) pops.push_back('{s_addr, s_dat});
      if (fl.size() > 0 && fl[0] == cyc) begin
        void'(fl.pop_front());
        if (mq.size() >= DEPTH && !do_pop) m_err = 1'b1;
        else mq.push_back('{m_addr, int'(conv_data)});
        m_addr = (m_addr + 1) % NOUT;
      end
      if (do_pop) void'(mq.pop_front());
      if (fd) m_draining = 1'b0;
      if (en) begin
        if (st) m_err = 1'b1;
        if ((m_pix / W) >= K-1 && (m_pix % W) >= K-1) fl.push_back(cyc + PL);
        m_pix++;
        if (m_pix == NPIX) begin
          m_pix      = 0;
          m_draining = 1'b1;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    s_vld  = (out_valid === 1'b1);
    s_addr = int'(out_addr);
    s_dat  = int'(out_data);
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("stall", 32'(stall), 32'(m_stall()));
    check("frame_done", 32'(frame_done), 32'(m_fd()));
    check("err", 32'(err), 32'(m_err));
    if (mq.size() > 0) begin
      check("out_addr", 32'(out_addr), 32'(mq[0].addr));
      check("out_data", 32'(out_data), 32'(mq[0].dat));
    end
    if (frame_done === 1'b1) fd_seen++;
    if (out_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
  end

  int pix_sent = 0;
  int target = NPIX;
  bit rnd_data = 1'b0;
  int start_cyc = -1;

  // en_mode: 0 idle, 1 forced, 2 whenever stall is low; rdy_mode: 0, 1, 2 random
  task automatic drive(input int en_mode, input int rdy_mode);
    @(negedge clk);
    case (en_mode)
      1:       en = 1'b1;
      2:       en = (stall === 1'b0) && (pix_sent < target);
      default: en = 1'b0;
    endcase
    out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    conv_data = rnd_data ? DBW'($urandom) : DBW'(cyc);
    if (en) begin
      pix_sent++;
      if (start_cyc < 0) start_cyc = cyc;
    end
  endtask

  task automatic send_frame(input int rdy_mode);
    int budget = 6000;
    while (pix_sent < target && budget > 0) begin
      drive(2, rdy_mode);
      budget--;
    end
    if (budget == 0) check("pixel_budget", 32'(pix_sent), 32'(target));
  endtask

  task automatic wait_fd(input int rdy_mode);
    int fd0 = fd_seen;
    int budget = 1000;
    while (fd_seen == fd0 && budget > 0) begin
      drive(0, rdy_mode);
      budget--;
    end
    if (budget == 0) check("frame_done_timeout", 32'(fd_seen - fd0), 32'd1);
    drive(0, rdy_mode);
  endtask

  task automatic new_frame();
    pix_sent  = 0;
    target    = NPIX;
    start_cyc = -1;
    pops.delete();
  endtask

  function automatic int addr_gaps(input int upto);
    int bad = 0;
    for (int i = 0; i < upto && i < pops.size(); i++)
      if (pops[i].addr != i) bad++;
    return bad;
  endfunction

  initial begin
    int fd0;
    logic [DBW-1:0] d0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    #2 reset = 1'b1;

    // full frame, always ready, conv_data = cycle count
    new_frame();
    rnd_data = 1'b0;
    first_vld_cyc = -1;
    fd0 = fd_seen;
    send_frame(1);
    wait_fd(1);
    check("ff_pop_count", 32'(pops.size()), 32'(NOUT));
    check("ff_addr_order", 32'(addr_gaps(NOUT)), 32'd0);
    check("ff_first_addr", 32'(pops.size() > 0 ? pops[0].addr : -1), 32'd0);
    check("ff_first_data", 32'(pops.size() > 0 ? pops[0].dat : -1), 32'(start_cyc + FIRST + PL));
    check("ff_first_latency", 32'(first_vld_cyc), 32'(start_cyc + FIRST + PL + 1));
    check("ff_last_addr", 32'(pops.size() > 0 ? pops[pops.size()-1].addr : -1), 32'(NOUT-1));
    check("ff_frame_done_count", 32'(fd_seen - fd0), 32'd1);
    check("ff_err", 32'(err), 32'd0);

    // backpressure from frame start
    new_frame();
    fd0 = fd_seen;
    repeat (FIRST + 30) drive(2, 0);
    check("bp_pixels_before_stall", 32'(pix_sent), 32'(FIRST + DEPTH));
    check("bp_stall", 32'(stall), 32'd1);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head_addr", 32'(out_addr), 32'd0);
    d0 = out_data;
    repeat (5) drive(0, 0);
    check("bp_data_stable", 32'(out_data), 32'(d0));
    check("bp_err", 32'(err), 32'd0);

    // forced pixel whose push lands on the same edge as a pop of the full FIFO
    drive(1, 0);
    drive(0, 0);
    drive(0, 1);
    drive(0, 0);
    check("pp_head_addr", 32'(out_addr), 32'd1);
    check("pp_stall", 32'(stall), 32'd1);
    check("pp_err", 32'(err), 32'd1);

    // forced pixel with nobody popping: dropped, address 5 skipped
    drive(1, 0);
    repeat (3) drive(0, 0);
    check("ov_head_addr", 32'(out_addr), 32'd1);
    rnd_data = 1'b1;
    send_frame(2);
    wait_fd(2);
    check("ov_pop_count", 32'(pops.size()), 32'(NOUT-1));
    check("ov_addr_head", 32'(addr_gaps(5)), 32'd0);
    check("ov_addr_skip", 32'(pops.size() > 5 ? pops[5].addr : -1), 32'd6);
    check("ov_frame_done_count", 32'(fd_seen - fd0), 32'd1);

    // reset mid-frame at row 10, err still set from above
    new_frame();
    fd0 = fd_seen;
    target = 10*W + 5;
    send_frame(2);
    @(negedge clk);
    #2 reset = 1'b0;
    en = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_stall", 32'(stall), 32'd0);
    check("mr_err", 32'(err), 32'd0);
    check("mr_out_addr", 32'(out_addr), 32'd0);
    check("mr_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    new_frame();
    send_frame(2);
    wait_fd(2);
    check("mr_pop_count", 32'(pops.size()), 32'(NOUT));
    check("mr_first_addr", 32'(pops.size() > 0 ? pops[0].addr : -1), 32'd0);
    check("mr_addr_order", 32'(addr_gaps(NOUT)), 32'd0);
    check("mr_frame_done_count", 32'(fd_seen - fd0), 32'd1);
    check("mr_err", 32'(err), 32'd0);

    // en during DRAIN
    new_frame();
    fd0 = fd_seen;
    send_frame(1);
    drive(1, 1);
    drive(1, 1);
    drive(0, 1);
    check("dr_err", 32'(err), 32'd1);
    wait_fd(1);
    check("dr_frame_done_count", 32'(fd_seen - fd0), 32'd1);
    check("dr_pop_count", 32'(pops.size()), 32'(NOUT));
    check("dr_stall_after", 32'(stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end
endmodule
